// File: rtl/fft_stage_sequencer.sv
// Issue/write-back sequencer for an in-place radix-2 DIT FFT.
// Walks LOG2N stages of N/2 butterflies, issuing one butterfly per cycle with
// read addresses and twiddle index, then idles PIPE_LAT drain cycles so the
// next stage never reads a location before the previous stage has written it.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               start a transform (sampled only when idle)
//   stall               hold the next issue while running
//   busy, done          run in progress / one-cycle completion pulse
//   stage               current stage index
//   rd_en, rd_addr_a/b  butterfly issue strobe and wing addresses
//   tw_addr             twiddle ROM index
//   wr_en, wr_addr_a/b  issue strobe and addresses delayed by PIPE_LAT
module fft_stage_sequencer #(
  parameter int unsigned LOG2N    = 3,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
);

  localparam int unsigned      DrainW    = $clog2(PIPE_LAT + 1);
  localparam int unsigned      TwW       = LOG2N - 1;
  localparam logic [LOG2N-1:0] KLast     = LOG2N'((1 << (LOG2N - 1)) - 1);
  localparam logic [LOG2N-1:0] StageLast = LOG2N'(LOG2N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  state_e              state_q, state_d;
  logic [LOG2N-1:0]    stage_q, stage_d;
  logic [LOG2N-1:0]    k_q, k_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic                issue;

  logic                busy_q, done_q, rd_en_q;
  logic [LOG2N-1:0]    rd_addr_a_q, rd_addr_b_q;
  logic [TwW-1:0]      tw_addr_q;
  logic [LOG2N-1:0]    rd_addr_a_d, rd_addr_b_d;
  logic [TwW-1:0]      tw_addr_d;

  logic                wr_en_pipe_q [PIPE_LAT];
  logic [LOG2N-1:0]    wr_a_pipe_q  [PIPE_LAT];
  logic [LOG2N-1:0]    wr_b_pipe_q  [PIPE_LAT];

  // Address generation for (stage_q, k_q).
  logic [LOG2N-1:0] mask, pos, grp, addr_a, addr_b;
  always_comb begin
    mask   = (LOG2N'(1) << stage_q) - LOG2N'(1);
    pos    = k_q & mask;
    grp    = k_q >> stage_q;
    addr_a = (grp << (stage_q + LOG2N'(1))) | pos;
    addr_b = addr_a | (LOG2N'(1) << stage_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    drain_d = drain_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          stage_d = '0;
          k_d     = '0;
        end
      end
      StRun: begin
        if (!stall) begin
          issue = 1'b1;
          if (k_q == KLast) begin
            state_d = StDrain;
            drain_d = DrainW'(PIPE_LAT);
          end else begin
            k_d = k_q + LOG2N'(1);
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainW'(1)) begin
          if (stage_q == StageLast) begin
            state_d = StFin;
          end else begin
            state_d = StRun;
            stage_d = stage_q + LOG2N'(1);
            k_d     = '0;
          end
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Read-side outputs are zeroed when nothing issues so the write pipe carries clean values.
  always_comb begin
    rd_addr_a_d = issue ? addr_a : '0;
    rd_addr_b_d = issue ? addr_b : '0;
    tw_addr_d   = issue ? TwW'(pos << (StageLast - stage_q)) : '0;
  end

  // Outputs lag the state by one cycle: busy covers first issue through last drain cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      stage_q     <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      busy_q      <= (state_q == StRun) || (state_q == StDrain);
      done_q      <= (state_q == StFin);
      rd_en_q     <= issue;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_addr_q   <= tw_addr_d;
    end
  end

  // Write-back delay line; advances every cycle independent of stall/state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        wr_en_pipe_q[i] <= 1'b0;
        wr_a_pipe_q[i]  <= '0;
        wr_b_pipe_q[i]  <= '0;
      end
    end else begin
      wr_en_pipe_q[0] <= rd_en_q;
      wr_a_pipe_q[0]  <= rd_addr_a_q;
      wr_b_pipe_q[0]  <= rd_addr_b_q;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        wr_en_pipe_q[i] <= wr_en_pipe_q[i-1];
        wr_a_pipe_q[i]  <= wr_a_pipe_q[i-1];
        wr_b_pipe_q[i]  <= wr_b_pipe_q[i-1];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr   = tw_addr_q;
  assign wr_en     = wr_en_pipe_q[PIPE_LAT-1];
  assign wr_addr_a = wr_a_pipe_q[PIPE_LAT-1];
  assign wr_addr_b = wr_b_pipe_q[PIPE_LAT-1];

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Control block for an in-place radix-2 DIT FFT engine. It walks LOG2N stages of N/2 butterflies each and issues one butterfly per cycle, with read addresses, twiddle address and read strobe for the coefficient/data RAM. It delays the write-back addresses to match the butterfly pipeline. It inserts drain cycles between stages so that no read of stage s+1 overtakes a write of stage s.

Parameters:
LOG2N, 3, log2 of FFT size N (N = 2^LOG2N, default 8-point)
PIPE_LAT, 2, butterfly latency in cycles from rd_en to matching wr_en (>=1)

Ports:
clk  in  1  system clock, all flops rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  request a new transform; sampled only in IDLE
stall  in  1  hold issue of the next butterfly (RUN state only)
busy  out  1  high from first issue cycle through last drain cycle
done  out  1  one-cycle pulse after final write-back
stage  out  LOG2N-bit encoding of 0..LOG2N-1  current stage index
rd_en  out  1  butterfly issued this cycle
rd_addr_a  out  LOG2N  upper-wing read address
rd_addr_b  out  LOG2N  lower-wing read address
tw_addr  out  LOG2N-1  twiddle ROM index
wr_en  out  1  rd_en delayed PIPE_LAT cycles
wr_addr_a  out  LOG2N  rd_addr_a delayed PIPE_LAT cycles
wr_addr_b  out  LOG2N  rd_addr_b delayed PIPE_LAT cycles

Behaviour:
- All outputs are registered. While reset is high: state=IDLE, all counters 0, all outputs 0, delay pipeline cleared (wr_en=0). This is immediate and asynchronous.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE: start=1 -> RUN with stage=0, k=0. Otherwise stay in IDLE.
- RUN: each cycle with stall=0, assert rd_en with addresses for (stage,k), then k++. If stall=1, rd_en=0 and k is held.
  - The issue with k=N/2-1 -> DRAIN, with the drain counter loaded to PIPE_LAT.
- DRAIN: rd_en=0 for exactly PIPE_LAT cycles; stall is ignored.
  - On exit, if stage<LOG2N-1: stage++, k=0, return to RUN.
  - Otherwise go to FIN.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- start outside IDLE is ignored; no queuing.
- busy=1 in RUN and DRAIN only.
- Address generation for stage s, butterfly k (0..N/2-1):
  - pos = k mod 2^s
  - grp = k >> s
  - rd_addr_a = grp*2^(s+1) + pos
  - rd_addr_b = rd_addr_a + 2^s
  - tw_addr = pos << (LOG2N-1-s)
  - All arithmetic is unsigned, truncated to the port width; no value exceeds N-1.
- Write side: wr_en, wr_addr_a and wr_addr_b are a PIPE_LAT-deep shift of rd_en, rd_addr_a and rd_addr_b.
  - The shift advances every cycle regardless of stall or state.
  - When wr_en=0, the wr_addr values are don't-care.
- Hazard rule: the first read of stage s+1 occurs no earlier than one cycle after the last wr_en of stage s.
- Latency without stall: start sampled at edge 0.
  - Stage s reads occupy cycles 1+s*(N/2+PIPE_LAT) .. s*(N/2+PIPE_LAT)+N/2.
  - done appears in cycle LOG2N*(N/2+PIPE_LAT)+1.
- Each stall cycle in RUN extends every later event by one cycle.
- Reset mid-transform aborts it: done is never asserted for the aborted run, and pending wr_en are flushed.

Test Plan:
- Defaults, start pulse at cycle 0, stall=0:
  - rd_en high cycles 1-4, 7-10, 13-16; wr_en high cycles 3-6, 9-12, 15-18.
  - busy high cycles 1-18; done high only at cycle 19.
- Defaults, address sequence:
  - stage0 (a,b,tw) = (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - stage1 (a,b,tw) = (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - stage2 (a,b,tw) = (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - wr_addr pairs match the read pairs 2 cycles later.
- stall=1 in cycles 2-3 of stage0:
  - issues at cycles 1,4,5,6 with pairs (0,1),(2,3),(4,5),(6,7); stall causes no duplicate or skipped pair.
  - done moves to cycle 21.
- start re-pulsed at cycle 5 and cycle 10 during a run: ignored, sequence identical to the first scenario. start held high through FIN: a second run begins with the first issue in the cycle after IDLE.
- reset asserted asynchronously at cycle 8 (mid stage1), released at cycle 10:
  - all outputs drop to 0 immediately; no done pulse; no wr_en after reset.
  - a new start yields the first-scenario timing.
- LOG2N=4, PIPE_LAT=3: 4 stages of 8 issues, each followed by 3 drain cycles.
  - stage3 pairs (0,8)..(7,15) with tw 0..7.
  - done at cycle 45.
